// File: rtl/vga_sync_gen_pkg.sv
// VGA 640x480@60 timing constants, the per-axis timing record and the sync polarity helper.
// Shared by the axis counter and the sync generator top.
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] total;
        logic [15:0] active;
        logic [15:0] front_porch;
        logic [15:0] sync_width;
    } axis_timing_t;

    localparam axis_timing_t H_640 = '{total: 16'd800, active: 16'd640, front_porch: 16'd16, sync_width: 16'd96};
    localparam axis_timing_t V_480 = '{total: 16'd525, active: 16'd480, front_porch: 16'd10, sync_width: 16'd2};

    // Pin level for a sync that is (or is not) inside its pulse window.
    function automatic logic sync_lvl(input logic active_low, input logic asserted);
        return asserted ^ active_low;
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle: counts, syncs, active flag and start strobes.
// master drives it (vga_sync_gen), slave consumes it (pins, pattern generators).
interface vga_sync_gen_if #(
    parameter int COUNT_WIDTH = 10
);
    logic                   o_hsync;
    logic                   o_vsync;
    logic [COUNT_WIDTH-1:0] o_col_count;
    logic [COUNT_WIDTH-1:0] o_row_count;
    logic                   o_active;
    logic                   o_line_start;
    logic                   o_frame_start;

    modport master (
        output o_hsync, o_vsync, o_col_count, o_row_count, o_active, o_line_start, o_frame_start
    );

    modport slave (
        input  o_hsync, o_vsync, o_col_count, o_row_count, o_active, o_line_start, o_frame_start
    );
endinterface

// File: rtl/vga_sync_gen_axis_counter.sv
// One raster axis: wrap-at-total counter with registered sync decode of the next position.
// o_wrap is combinational (advancing out of the last position); o_active_next decodes the next position.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int           COUNT_WIDTH     = 10,
    parameter axis_timing_t TIMING          = H_640,
    parameter bit           SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                   clock,
    input  logic                   i_reset,
    input  logic                   i_advance,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic                   o_sync,
    output logic                   o_active_next,
    output logic                   o_wrap
);
    localparam int SYNC_FIRST = int'(TIMING.active) + int'(TIMING.front_porch);
    localparam int SYNC_LAST  = SYNC_FIRST + int'(TIMING.sync_width) - 1;
    localparam logic [COUNT_WIDTH-1:0] LAST_POS = COUNT_WIDTH'(int'(TIMING.total) - 1);

    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_next;
    logic                   r_sync;
    logic                   w_at_last;
    logic                   w_in_sync;

    assign w_at_last = (r_count == LAST_POS);
    assign o_wrap    = i_advance && w_at_last;

    always_comb begin
        w_next = r_count;
        if (i_advance) begin
            w_next = w_at_last ? '0 : r_count + COUNT_WIDTH'(1);
        end
    end

    // Extra bit keeps the window bounds exact when a bound equals 2**COUNT_WIDTH.
    assign w_in_sync     = ({1'b0, w_next} >= (COUNT_WIDTH+1)'(SYNC_FIRST)) &&
                           ({1'b0, w_next} <= (COUNT_WIDTH+1)'(SYNC_LAST));
    assign o_active_next = ({1'b0, w_next} <  (COUNT_WIDTH+1)'(TIMING.active));

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_count <= LAST_POS;
            r_sync  <= sync_lvl(SYNC_ACTIVE_LOW, 1'b0);
        end else if (i_advance) begin
            r_count <= w_next;
            r_sync  <= sync_lvl(SYNC_ACTIVE_LOW, w_in_sync);
        end
    end

    assign o_count = r_count;
    assign o_sync  = r_sync;
endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing source: column/row counters with registered syncs, active flag and start strobes.
// Zero latency between counts and decodes; i_enable low freezes the raster and silences the strobes.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int TOTAL_COLS      = int'(H_640.total),
    parameter int TOTAL_ROWS      = int'(V_480.total),
    parameter int ACTIVE_COLS     = int'(H_640.active),
    parameter int ACTIVE_ROWS     = int'(V_480.active),
    parameter int H_FRONT_PORCH   = int'(H_640.front_porch),
    parameter int H_SYNC_WIDTH    = int'(H_640.sync_width),
    parameter int V_FRONT_PORCH   = int'(V_480.front_porch),
    parameter int V_SYNC_WIDTH    = int'(V_480.sync_width),
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int COUNT_WIDTH     = 10
) (
    input  logic           clock,
    input  logic           i_reset,
    input  logic           i_enable,
    vga_sync_gen_if.master bus
);
    localparam axis_timing_t H_T = '{total: 16'(TOTAL_COLS), active: 16'(ACTIVE_COLS),
                                     front_porch: 16'(H_FRONT_PORCH), sync_width: 16'(H_SYNC_WIDTH)};
    localparam axis_timing_t V_T = '{total: 16'(TOTAL_ROWS), active: 16'(ACTIVE_ROWS),
                                     front_porch: 16'(V_FRONT_PORCH), sync_width: 16'(V_SYNC_WIDTH)};

    if (TOTAL_COLS > 2**COUNT_WIDTH || TOTAL_ROWS > 2**COUNT_WIDTH) begin : g_bad_width
        $error("vga_sync_gen: totals do not fit COUNT_WIDTH");
    end
    if (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH > TOTAL_COLS) begin : g_bad_hsync
        $error("vga_sync_gen: hsync ends outside the line");
    end
    if (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH > TOTAL_ROWS) begin : g_bad_vsync
        $error("vga_sync_gen: vsync ends outside the frame");
    end

    logic [COUNT_WIDTH-1:0] w_col;
    logic [COUNT_WIDTH-1:0] w_row;
    logic                   w_hsync;
    logic                   w_vsync;
    logic                   w_col_act;
    logic                   w_row_act;
    logic                   w_col_wrap;
    logic                   w_row_wrap;
    logic                   r_active;
    logic                   r_line_start;
    logic                   r_frame_start;

    vga_axis_counter #(.COUNT_WIDTH(COUNT_WIDTH), .TIMING(H_T), .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_col (
        .clock         (clock),
        .i_reset       (i_reset),
        .i_advance     (i_enable),
        .o_count       (w_col),
        .o_sync        (w_hsync),
        .o_active_next (w_col_act),
        .o_wrap        (w_col_wrap)
    );

    // The row only moves on a column wrap, so vsync edges land on col 0.
    vga_axis_counter #(.COUNT_WIDTH(COUNT_WIDTH), .TIMING(V_T), .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_row (
        .clock         (clock),
        .i_reset       (i_reset),
        .i_advance     (w_col_wrap),
        .o_count       (w_row),
        .o_sync        (w_vsync),
        .o_active_next (w_row_act),
        .o_wrap        (w_row_wrap)
    );

    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_active      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= w_col_wrap;
            r_frame_start <= w_row_wrap;
            if (i_enable) begin
                r_active <= w_col_act && w_row_act;
            end
        end
    end

    assign bus.o_col_count   = w_col;
    assign bus.o_row_count   = w_row;
    assign bus.o_hsync       = w_hsync;
    assign bus.o_vsync       = w_vsync;
    assign bus.o_active      = r_active;
    assign bus.o_line_start  = r_line_start;
    assign bus.o_frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a 640x480 instance and a tiny 10x4 active-high instance share stimulus,
// both checked against a linear-pixel-index raster model.
module tb_vga_sync_gen;
    localparam int A_TC = 800, A_TR = 525, A_AC = 640, A_AR = 480;
    localparam int A_HS0 = 656, A_HS1 = 751, A_VS0 = 490, A_VS1 = 491;
    localparam int B_TC = 10, B_TR = 4, B_AC = 6, B_AR = 2;
    localparam int B_HS0 = 7, B_HS1 = 8, B_VS0 = 3, B_VS1 = 3;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    logic en    = 1'b0;
    always #5 clock = ~clock;

    vga_sync_gen_if #(.COUNT_WIDTH(10)) bus_a ();
    vga_sync_gen_if #(.COUNT_WIDTH(4))  bus_b ();

    vga_sync_gen u_dut_a (
        .clock    (clock),
        .i_reset  (rst),
        .i_enable (en),
        .bus      (bus_a)
    );

    vga_sync_gen #(
        .TOTAL_COLS(10), .TOTAL_ROWS(4), .ACTIVE_COLS(6), .ACTIVE_ROWS(2),
        .H_FRONT_PORCH(1), .H_SYNC_WIDTH(2), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1),
        .SYNC_ACTIVE_LOW(1'b0), .COUNT_WIDTH(4)
    ) u_dut_b (
        .clock    (clock),
        .i_reset  (rst),
        .i_enable (en),
        .bus      (bus_b)
    );

    // Model: pixel index within the frame; stb = last edge advanced; fresh = no advance since reset.
    int pa, pb;
    bit stb, fresh;
    always @(posedge clock) begin
        if (rst) begin
            pa = A_TC*A_TR - 1; pb = B_TC*B_TR - 1; stb = 1'b0; fresh = 1'b1;
        end else if (en) begin
            pa = (pa + 1) % (A_TC*A_TR); pb = (pb + 1) % (B_TC*B_TR); stb = 1'b1; fresh = 1'b0;
        end else begin
            stb = 1'b0;
        end
    end

    function automatic logic [24:0] expect_vec(int p, bit s, bit fr, int tc, int ac, int ar,
                                               int hs0, int hs1, int vs0, int vs1, bit low);
        int col, row;
        bit h, v, act;
        col = p % tc;
        row = p / tc;
        h   = (col >= hs0) && (col <= hs1) && !fr;
        v   = (row >= vs0) && (row <= vs1) && !fr;
        act = (col < ac) && (row < ar) && !fr;
        return {10'(col), 10'(row), h ^ low, v ^ low, act, s && (col == 0), s && (p == 0)};
    endfunction

    logic [24:0] act_a, act_b, exp_a, exp_b;
    assign act_a = {bus_a.o_col_count, bus_a.o_row_count, bus_a.o_hsync, bus_a.o_vsync,
                    bus_a.o_active, bus_a.o_line_start, bus_a.o_frame_start};
    assign act_b = {6'd0, bus_b.o_col_count, 6'd0, bus_b.o_row_count, bus_b.o_hsync, bus_b.o_vsync,
                    bus_b.o_active, bus_b.o_line_start, bus_b.o_frame_start};
    assign exp_a = expect_vec(pa, stb, fresh, A_TC, A_AC, A_AR, A_HS0, A_HS1, A_VS0, A_VS1, 1'b1);
    assign exp_b = expect_vec(pb, stb, fresh, B_TC, B_AC, B_AR, B_HS0, B_HS1, B_VS0, B_VS1, 1'b0);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++;
            if (act_a !== exp_a) begin n_fail++; $display("FAIL reset_a: got %h expected %h", act_a, exp_a); end
            n_checks++;
            if (act_b !== exp_b) begin n_fail++; $display("FAIL reset_b: got %h expected %h", act_b, exp_b); end
        end
        n_checks++;
        if (bus_b.o_vsync !== 1'b0) begin n_fail++; $display("FAIL reset_b_vsync: got %b expected 0", bus_b.o_vsync); end
        // Held by i_enable low after reset: syncs must keep the deasserted level.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++;
            if (act_b !== exp_b) begin n_fail++; $display("FAIL hold_after_reset_b: got %h expected %h", act_b, exp_b); end
        end
    endtask

    task automatic test_first_line();
        int hs_low = 0, act_cnt = 0, ls0 = -1, ls1 = -1;
        en = 1'b1;
        for (int i = 0; i <= A_TC; i++) begin
            @(negedge clock);
            n_checks++;
            if (act_a !== exp_a) begin n_fail++; $display("FAIL line_a cyc %0d: got %h expected %h", i, act_a, exp_a); end
            if (i < A_TC && bus_a.o_hsync === 1'b0) hs_low++;
            if (i < A_TC && bus_a.o_active === 1'b1) act_cnt++;
            if (bus_a.o_line_start === 1'b1) begin
                if (ls0 < 0) ls0 = i; else if (ls1 < 0) ls1 = i;
            end
        end
        n_checks++;
        if (hs_low !== 96) begin n_fail++; $display("FAIL hsync_width: got %0d expected 96", hs_low); end
        n_checks++;
        if (act_cnt !== 640) begin n_fail++; $display("FAIL active_width: got %0d expected 640", act_cnt); end
        n_checks++;
        if (ls0 !== 0 || ls1 !== 800) begin n_fail++; $display("FAIL line_period: got %0d,%0d expected 0,800", ls0, ls1); end
    endtask

    task automatic test_frames();
        int vs_hi = 0, hs_hi = 0, fs0 = -1, fs1 = -1;
        en = 1'b1;
        for (int i = 0; i < 2*B_TC*B_TR; i++) begin
            @(negedge clock);
            n_checks++;
            if (act_b !== exp_b) begin n_fail++; $display("FAIL frame_b cyc %0d: got %h expected %h", i, act_b, exp_b); end
            if (bus_b.o_vsync === 1'b1) begin
                vs_hi++;
                n_checks++;
                if (bus_b.o_row_count !== 4'd3) begin n_fail++; $display("FAIL vsync_row: got %0d expected 3", bus_b.o_row_count); end
            end
            if (bus_b.o_hsync === 1'b1) begin
                hs_hi++;
                n_checks++;
                if (bus_b.o_col_count < 4'd7 || bus_b.o_col_count > 4'd8) begin
                    n_fail++; $display("FAIL hsync_col: got %0d expected 7..8", bus_b.o_col_count);
                end
            end
            if (bus_b.o_frame_start === 1'b1) begin
                if (fs0 < 0) fs0 = i; else if (fs1 < 0) fs1 = i;
            end
        end
        n_checks++;
        if (vs_hi !== 20) begin n_fail++; $display("FAIL vsync_cycles: got %0d expected 20", vs_hi); end
        n_checks++;
        if (hs_hi !== 16) begin n_fail++; $display("FAIL hsync_cycles: got %0d expected 16", hs_hi); end
        n_checks++;
        if (fs0 < 0 || fs1 - fs0 !== 40) begin n_fail++; $display("FAIL frame_period: got %0d,%0d expected 40 apart", fs0, fs1); end
    endtask

    task automatic test_enable_gap();
        int budget = 0;
        rst = 1'b1; en = 1'b0;
        @(negedge clock);
        rst = 1'b0; en = 1'b1;
        while (pa != 3*A_TC + 100 && budget < 4000) begin
            @(negedge clock);
            budget++;
        end
        n_checks++;
        if (budget >= 4000) begin n_fail++; $display("FAIL gap_reach: got timeout expected col 100 row 3"); end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_checks++;
            if (act_a !== exp_a) begin n_fail++; $display("FAIL gap_hold_a: got %h expected %h", act_a, exp_a); end
            n_checks++;
            if (bus_a.o_col_count !== 10'd100 || bus_a.o_row_count !== 10'd3 || bus_a.o_line_start !== 1'b0) begin
                n_fail++; $display("FAIL gap_frozen: got col %0d row %0d expected col 100 row 3", bus_a.o_col_count, bus_a.o_row_count);
            end
        end
        en = 1'b1;
        @(negedge clock);
        n_checks++;
        if (bus_a.o_col_count !== 10'd101 || bus_a.o_line_start !== 1'b0) begin
            n_fail++; $display("FAIL gap_resume: got col %0d ls %b expected col 101 ls 0", bus_a.o_col_count, bus_a.o_line_start);
        end
    endtask

    task automatic test_mid_reset();
        int budget = 0;
        en = 1'b1;
        while (pa != 4*A_TC + 700 && budget < 2000) begin
            @(negedge clock);
            budget++;
        end
        n_checks++;
        if (budget >= 2000) begin n_fail++; $display("FAIL mrst_reach: got timeout expected col 700 row 4"); end
        rst = 1'b1;
        @(negedge clock);
        n_checks++;
        if (act_a !== {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL mrst_value: got %h expected col 799 row 524 syncs 1", act_a);
        end
        n_checks++;
        if (act_b !== exp_b) begin n_fail++; $display("FAIL mrst_b: got %h expected %h", act_b, exp_b); end
        rst = 1'b0;
        @(negedge clock);
        n_checks++;
        if (act_a !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL mrst_restart: got %h expected (0,0) with both strobes", act_a);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            en  = ($urandom % 4) != 0;
            rst = ($urandom % 300) == 0;
            @(negedge clock);
            n_checks++;
            if (act_a !== exp_a) begin n_fail++; $display("FAIL rand_a cyc %0d: got %h expected %h", i, act_a, exp_a); end
            n_checks++;
            if (act_b !== exp_b) begin n_fail++; $display("FAIL rand_b cyc %0d: got %h expected %h", i, act_b, exp_b); end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_frames();
        test_enable_gap();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
